// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the register-file write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv_wb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int XLEN_DEF   = 32;
    localparam int REG_X0     = 0;

    // One pending register-file write: destination and value.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending write-back requests.
// Latency: a pushed entry becomes visible at head on the following cycle (no bypass).
// Backpressure: push is ignored while full, even when a pop occurs in the same cycle.
module wb_fifo
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t din,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t           mem_q [DEPTH];
    logic    [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic    [CW-1:0]  count_q;
    logic              push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Storage array: data only, no reset needed since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    // Pointers wrap naturally (power-of-two depth); the extra count bit tells full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and buffered MUL/DIV results onto one register-file write port; tracks busy registers.
// Latency: ALU 1 cycle; MUL/DIV at least 2 cycles from handshake (buffer, then output register).
// Backpressure: ALU never stalls and wins the port; MUL/DIV waits in the buffer, md_ready = !full.
module regfile_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int XLEN     = XLEN_DEF,
    parameter int REGFILE  = 32,
    parameter int MD_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              md_valid,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic [XLEN-1:0]   md_data,
    input  logic              issue_lock,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              we,
    output logic [ADDR_W-1:0] rd,
    output logic [XLEN-1:0]   write_data,
    output logic              waw_err
);

    wb_req_t              md_req, md_head;
    logic                 md_full, md_empty, md_push, md_pop;
    logic                 alu_eff, head_live;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_rd;
    logic [XLEN-1:0]      sel_data;
    logic [REGFILE-1:0]   busy_q, busy_d;
    logic                 we_q, waw_q;
    logic [ADDR_W-1:0]    rd_q;
    logic [XLEN-1:0]      data_q;

    // Ready is held low during reset so nothing is accepted into a buffer being cleared.
    assign md_ready   = rst_n && !md_full;
    assign md_push    = md_valid && md_ready;
    assign md_req     = '{rd: md_rd, data: md_data};

    assign alu_eff    = alu_valid && (alu_rd != ADDR_W'(REG_X0));
    assign md_pop     = !alu_eff && !md_empty;
    assign head_live  = md_head.rd != ADDR_W'(REG_X0);

    wb_fifo #(.DEPTH(MD_DEPTH)) u_md_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (md_push),
        .din   (md_req),
        .pop   (md_pop),
        .full  (md_full),
        .empty (md_empty),
        .head  (md_head)
    );

    // Port selection: ALU first, else buffer head; an x0 head is popped but produces no write.
    always_comb begin
        sel_we   = 1'b0;
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (alu_eff) begin
            sel_we = 1'b1;
        end else if (md_pop && head_live) begin
            sel_we   = 1'b1;
            sel_rd   = md_head.rd;
            sel_data = md_head.data;
        end
    end

    // Scoreboard next state: clear on selected pop, then set on issue so a same-cycle relock wins.
    always_comb begin
        busy_d = busy_q;
        if (md_pop && head_live) busy_d[md_head.rd] = 1'b0;
        if (issue_lock && (issue_rd != ADDR_W'(REG_X0))) busy_d[issue_rd] = 1'b1;
        busy_d[REG_X0] = 1'b0;
    end

    // Registered write port and scoreboard; address/data hold when nothing is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            waw_q  <= 1'b0;
            busy_q <= '0;
        end else begin
            we_q   <= sel_we;
            waw_q  <= alu_eff && busy_q[alu_rd];
            busy_q <= busy_d;
            if (sel_we) begin
                rd_q   <= sel_rd;
                data_q <= sel_data;
            end
        end
    end

    assign rs1_busy   = busy_q[rs1];
    assign rs2_busy   = busy_q[rs2];
    assign we         = we_q;
    assign rd         = rd_q;
    assign write_data = data_q;
    assign waw_err    = waw_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based reference model.
// Latency: model predicts the registered port one edge after each decision.
// Backpressure: model accepts MUL/DIV offers only while fewer than two results are queued.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk, rst_n;
    logic        alu_valid, md_valid, md_ready, issue_lock;
    logic [4:0]  alu_rd, md_rd, issue_rd, rs1, rs2, rd;
    logic [31:0] alu_data, md_data, write_data;
    logic        rs1_busy, rs2_busy, we, waw_err;

    regfile_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .md_valid   (md_valid),
        .md_ready   (md_ready),
        .md_rd      (md_rd),
        .md_data    (md_data),
        .issue_lock (issue_lock),
        .issue_rd   (issue_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .we         (we),
        .rd         (rd),
        .write_data (write_data),
        .waw_err    (waw_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        busy_m [32];
    logic        exp_we, exp_waw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
        exp_we   = 1'b0;
        exp_waw  = 1'b0;
        exp_rd   = '0;
        exp_data = '0;
    endtask

    // One clock: drive at the falling edge, check, advance the model, step to the next falling edge.
    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic il, input logic [4:0] ir,
                         input logic [4:0] r1, input logic [4:0] r2);
        logic accept;
        ent_t e;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        md_valid  = mv; md_rd  = mr; md_data  = md;
        issue_lock = il; issue_rd = ir;
        rs1 = r1; rs2 = r2;
        #1;
        check("md_ready",   {31'd0, md_ready},   {31'd0, mq.size() < DEPTH});
        check("rs1_busy",   {31'd0, rs1_busy},   {31'd0, busy_m[r1]});
        check("rs2_busy",   {31'd0, rs2_busy},   {31'd0, busy_m[r2]});
        check("we",         {31'd0, we},         {31'd0, exp_we});
        check("rd",         {27'd0, rd},         {27'd0, exp_rd});
        check("write_data", write_data,          exp_data);
        check("waw_err",    {31'd0, waw_err},    {31'd0, exp_waw});

        accept  = mv && (mq.size() < DEPTH);
        exp_waw = 1'b0;
        exp_we  = 1'b0;
        if (av && ar != 0) begin
            exp_we   = 1'b1;
            exp_rd   = ar;
            exp_data = ad;
            exp_waw  = busy_m[ar];
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.rd != 0) begin
                exp_we     = 1'b1;
                exp_rd     = e.rd;
                exp_data   = e.data;
                busy_m[e.rd] = 1'b0;
            end
        end
        if (accept) begin
            e.rd = mr; e.data = md;
            mq.push_back(e);
        end
        if (il && ir != 0) busy_m[ir] = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        md_valid = 0; md_rd = 0; md_data = 0;
        issue_lock = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
        model_reset();
        @(negedge clk);
        #1;
        check("reset_md_ready", {31'd0, md_ready}, 32'd0);
        check("reset_we",       {31'd0, we},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU path, then an x0 ALU write that must not occupy the port
        cycle(1, 5, 32'h0000_1234, 0, 0, 0, 0, 0, 5, 0);
        cycle(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0);

        // Collision: ALU x3 and MUL/DIV x7 together
        cycle(1, 3, 32'h0000_0033, 1, 7, 32'hDEAD_BEEF, 0, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);
        idle(0, 0);

        // Backpressure: ALU every cycle, three offers; the third waits for room
        cycle(1, 1, 32'h11, 1, 10, 32'hA0, 0, 0, 0, 0);
        cycle(1, 2, 32'h22, 1, 11, 32'hA1, 0, 0, 0, 0);
        cycle(1, 1, 32'h33, 1, 12, 32'hA2, 0, 0, 0, 0);
        cycle(0, 0, 0,      1, 12, 32'hA2, 0, 0, 0, 0);
        cycle(0, 0, 0,      1, 12, 32'hA2, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) idle(0, 0);

        // Scoreboard: lock x9, clear on pop, same-cycle relock keeps it busy
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
        cycle(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
        cycle(0, 0, 0, 1, 9, 32'h98, 0, 0, 9, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        idle(9, 0);

        // WAW: lock x4, ALU writes x4
        cycle(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
        cycle(1, 4, 32'h44, 0, 0, 0, 0, 0, 4, 0);
        idle(4, 9);
        // x0 buffer head is popped and dropped
        cycle(0, 0, 0, 1, 0, 32'h5A5A, 0, 0, 0, 0);
        idle(0, 0);
        idle(0, 0);

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        // Async reset mid-burst with two queued results
        cycle(1, 6, 32'h66, 1, 13, 32'hC0, 1, 13, 0, 0);
        cycle(1, 6, 32'h67, 1, 14, 32'hC1, 1, 14, 0, 0);
        alu_valid = 0; md_valid = 0; issue_lock = 0;
        rst_n = 1'b0;
        #1;
        check("arst_we",       {31'd0, we},       32'd0);
        check("arst_md_ready", {31'd0, md_ready}, 32'd0);
        check("arst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(13, 14);
        idle(13, 14);
        idle(6, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
